bus_mux: RTL and testbench
==========================

BUS_MUX -- requirements
Module: bus_mux

Interface
REQ-001 SHALL have port clock, input, 1 bit: single system clock; only the error-flag register is clocked.
REQ-002 SHALL have port clear, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have ports R0_BusMuxIn..R15_BusMuxIn, input, 32 bits each: general-register bus sources.
REQ-004 SHALL have ports HI_BusMuxIn, LO_BusMuxIn, RZ_HI_BusMuxIn, RZ_LO_BusMuxIn, PC_BusMuxIn, MDR_Bus_lines, Inport_BusIn, C_sign_extended, input, 32 bits each: special bus sources.
REQ-005 SHALL have port Encoder_signals, input, 24 bits: one-hot "drive bus" requests, bit i = source i.
REQ-006 SHALL have port BusMuxOut, output, 32 bits: the bus value.
REQ-007 SHALL have port Encoder_select_signals_check, output, 5 bits: encoded select code, for debug.
REQ-008 SHALL have port Bus_conflict, output, 1 bit: sticky flag, set when more than one request bit was high on a clock edge.

Function
REQ-009 Source index map SHALL be: R0..R15 = 0..15, HI = 16, LO = 17, RZ_HI = 18, RZ_LO = 19, PC = 20, MDR = 21, Inport = 22, C_sign_extended = 23.
REQ-010 Encoder: Encoder_signals bit i high (exactly one bit) SHALL give select code i (5-bit unsigned).
REQ-011 Multiple request bits high: the highest-index asserted bit SHALL win.
REQ-012 Encoder_signals all zero: select code SHALL be 5'd31 (NONE).
REQ-013 Codes 24..31, including NONE: BusMuxOut SHALL be 32'h0000_0000.
REQ-014 BusMuxOut and Encoder_select_signals_check SHALL be purely combinational from the inputs, with zero-cycle latency.
REQ-015 BusMuxOut and Encoder_select_signals_check SHALL NOT depend on clock or clear.
REQ-016 Source data SHALL pass unmodified, with no sign or zero manipulation; C_sign_extended is already extended upstream.
REQ-017 Bus_conflict SHALL be set at a rising clock edge when popcount(Encoder_signals) > 1.
REQ-018 Once set, Bus_conflict SHALL hold until reset.
REQ-019 Conflict-free cycles SHALL NOT clear Bus_conflict.
REQ-020 Encoder_signals = 0 SHALL NOT count as a conflict.

Reset
REQ-021 clear low SHALL immediately force Bus_conflict to 0, asynchronously, independent of clock.
REQ-022 While clear is low, Bus_conflict SHALL stay 0.
REQ-023 Combinational outputs SHALL be unaffected by reset.
REQ-024 Reset asserted mid-operation SHALL lose the sticky conflict history only; no other state exists.

Structure
REQ-025 A shared package SHALL hold the 5-bit select-code constants (SEL_R0..SEL_R15, SEL_HI, SEL_LO, SEL_RZ_HI, SEL_RZ_LO, SEL_PC, SEL_MDR, SEL_INPORT, SEL_CSIGN, SEL_NONE = 31).
REQ-026 The shared package SHALL also hold the constants NUM_SOURCES = 24 and BUS_WIDTH = 32.
REQ-027 There SHALL be one sub-module, encoder_24_to_5, implementing REQ-010 to REQ-012.
REQ-028 bus_mux SHALL instantiate encoder_24_to_5 and implement the 24:1 32-bit mux, indexed by code, plus the conflict register.

Verification
REQ-029 Encoder_signals = 24'h0 with all sources nonzero -> BusMuxOut = 32'h0; check code = 31.
REQ-030 R0 = 32'hAAAA_AAAA, others 0, Encoder_signals = 24'h000001 -> BusMuxOut = 32'hAAAA_AAAA within one delta; code = 0.
REQ-031 R1 = 32'hBBBB_BBBB, Encoder_signals = 24'h000002 -> BusMuxOut = 32'hBBBB_BBBB; code = 1.
REQ-032 C_sign_extended = 32'hCCCC_CCCC, Encoder_signals = 24'h800000 -> BusMuxOut = 32'hCCCC_CCCC; code = 23.
REQ-033 Walking-one sweep over all 24 bits, each source loaded with a unique value (32'h1000_0000 + i) -> BusMuxOut equals that source's value; code = i.
REQ-034 Conflict and reset sequence SHALL be checked as follows:
- Encoder_signals = 24'h000003 with R0 = 1, R1 = 2 -> BusMuxOut = 2 (R1 wins).
- Next clock edge -> Bus_conflict = 1.
- Return to 24'h000001 for several cycles -> Bus_conflict stays 1.
- Pulse clear low between clock edges -> Bus_conflict = 0 immediately.

Source files
------------

// File: rtl/bus_mux_pkg.sv
// bus_mux_pkg: select codes and sizes shared by the bus multiplexer
package bus_mux_pkg;
    localparam int NUM_SOURCES = 24;
    localparam int BUS_WIDTH   = 32;
    localparam logic [4:0] SEL_R0     = 5'd0;
    localparam logic [4:0] SEL_R1     = 5'd1;
    localparam logic [4:0] SEL_R2     = 5'd2;
    localparam logic [4:0] SEL_R3     = 5'd3;
    localparam logic [4:0] SEL_R4     = 5'd4;
    localparam logic [4:0] SEL_R5     = 5'd5;
    localparam logic [4:0] SEL_R6     = 5'd6;
    localparam logic [4:0] SEL_R7     = 5'd7;
    localparam logic [4:0] SEL_R8     = 5'd8;
    localparam logic [4:0] SEL_R9     = 5'd9;
    localparam logic [4:0] SEL_R10    = 5'd10;
    localparam logic [4:0] SEL_R11    = 5'd11;
    localparam logic [4:0] SEL_R12    = 5'd12;
    localparam logic [4:0] SEL_R13    = 5'd13;
    localparam logic [4:0] SEL_R14    = 5'd14;
    localparam logic [4:0] SEL_R15    = 5'd15;
    localparam logic [4:0] SEL_HI     = 5'd16;
    localparam logic [4:0] SEL_LO     = 5'd17;
    localparam logic [4:0] SEL_RZ_HI  = 5'd18;
    localparam logic [4:0] SEL_RZ_LO  = 5'd19;
    localparam logic [4:0] SEL_PC     = 5'd20;
    localparam logic [4:0] SEL_MDR    = 5'd21;
    localparam logic [4:0] SEL_INPORT = 5'd22;
    localparam logic [4:0] SEL_CSIGN  = 5'd23;
    localparam logic [4:0] SEL_NONE   = 5'd31;
endpackage

// File: rtl/encoder_24_to_5.sv
// encoder_24_to_5: priority encoder, highest set request wins, none gives SEL_NONE
module encoder_24_to_5
    import bus_mux_pkg::*;
(
    input  logic [NUM_SOURCES-1:0] req,
    output logic [4:0]             code
);
    always_comb begin
        code = SEL_NONE;
        for (int i = 0; i < NUM_SOURCES; i++)
            if (req[i]) code = 5'(i);
    end
endmodule

// File: rtl/bus_mux.sv
// bus_mux: 24:1 combinational bus multiplexer with a sticky multi-driver flag
module bus_mux
    import bus_mux_pkg::*;
(
    input  logic                 clock,
    input  logic                 clear,
    input  logic [BUS_WIDTH-1:0] R0_BusMuxIn,
    input  logic [BUS_WIDTH-1:0] R1_BusMuxIn,
    input  logic [BUS_WIDTH-1:0] R2_BusMuxIn,
    input  logic [BUS_WIDTH-1:0] R3_BusMuxIn,
    input  logic [BUS_WIDTH-1:0] R4_BusMuxIn,
    input  logic [BUS_WIDTH-1:0] R5_BusMuxIn,
    input  logic [BUS_WIDTH-1:0] R6_BusMuxIn,
    input  logic [BUS_WIDTH-1:0] R7_BusMuxIn,
    input  logic [BUS_WIDTH-1:0] R8_BusMuxIn,
    input  logic [BUS_WIDTH-1:0] R9_BusMuxIn,
    input  logic [BUS_WIDTH-1:0] R10_BusMuxIn,
    input  logic [BUS_WIDTH-1:0] R11_BusMuxIn,
    input  logic [BUS_WIDTH-1:0] R12_BusMuxIn,
    input  logic [BUS_WIDTH-1:0] R13_BusMuxIn,
    input  logic [BUS_WIDTH-1:0] R14_BusMuxIn,
    input  logic [BUS_WIDTH-1:0] R15_BusMuxIn,
    input  logic [BUS_WIDTH-1:0] HI_BusMuxIn,
    input  logic [BUS_WIDTH-1:0] LO_BusMuxIn,
    input  logic [BUS_WIDTH-1:0] RZ_HI_BusMuxIn,
    input  logic [BUS_WIDTH-1:0] RZ_LO_BusMuxIn,
    input  logic [BUS_WIDTH-1:0] PC_BusMuxIn,
    input  logic [BUS_WIDTH-1:0] MDR_Bus_lines,
    input  logic [BUS_WIDTH-1:0] Inport_BusIn,
    input  logic [BUS_WIDTH-1:0] C_sign_extended,
    input  logic [NUM_SOURCES-1:0] Encoder_signals,
    output logic [BUS_WIDTH-1:0] BusMuxOut,
    output logic [4:0]           Encoder_select_signals_check,
    output logic                 Bus_conflict
);
    logic [BUS_WIDTH-1:0] src [NUM_SOURCES];
    logic [4:0]           sel;

    assign src = '{R0_BusMuxIn, R1_BusMuxIn, R2_BusMuxIn, R3_BusMuxIn,
                   R4_BusMuxIn, R5_BusMuxIn, R6_BusMuxIn, R7_BusMuxIn,
                   R8_BusMuxIn, R9_BusMuxIn, R10_BusMuxIn, R11_BusMuxIn,
                   R12_BusMuxIn, R13_BusMuxIn, R14_BusMuxIn, R15_BusMuxIn,
                   HI_BusMuxIn, LO_BusMuxIn, RZ_HI_BusMuxIn, RZ_LO_BusMuxIn,
                   PC_BusMuxIn, MDR_Bus_lines, Inport_BusIn, C_sign_extended};

    encoder_24_to_5 u_enc (.req(Encoder_signals), .code(sel));

    assign Encoder_select_signals_check = sel;
    assign BusMuxOut = (sel <= SEL_CSIGN) ? src[sel] : '0;

    always_ff @(posedge clock or negedge clear)
        if (!clear) Bus_conflict <= 1'b0;
        else if ($countones(Encoder_signals) > 1) Bus_conflict <= 1'b1;
endmodule

// File: tb/tb_bus_mux.sv
// tb_bus_mux: directed and random checks of bus_mux against a priority/sticky-flag model
module tb_bus_mux;
    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] src [24];
    logic [23:0] enc = '0;
    logic [31:0] bus;
    logic [4:0]  code;
    logic        conflict;
    logic        m_conf = 1'b0;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clock = ~clock;

    bus_mux dut (
        .clock(clock), .clear(clear),
        .R0_BusMuxIn(src[0]), .R1_BusMuxIn(src[1]), .R2_BusMuxIn(src[2]), .R3_BusMuxIn(src[3]),
        .R4_BusMuxIn(src[4]), .R5_BusMuxIn(src[5]), .R6_BusMuxIn(src[6]), .R7_BusMuxIn(src[7]),
        .R8_BusMuxIn(src[8]), .R9_BusMuxIn(src[9]), .R10_BusMuxIn(src[10]), .R11_BusMuxIn(src[11]),
        .R12_BusMuxIn(src[12]), .R13_BusMuxIn(src[13]), .R14_BusMuxIn(src[14]), .R15_BusMuxIn(src[15]),
        .HI_BusMuxIn(src[16]), .LO_BusMuxIn(src[17]), .RZ_HI_BusMuxIn(src[18]), .RZ_LO_BusMuxIn(src[19]),
        .PC_BusMuxIn(src[20]), .MDR_Bus_lines(src[21]), .Inport_BusIn(src[22]), .C_sign_extended(src[23]),
        .Encoder_signals(enc), .BusMuxOut(bus),
        .Encoder_select_signals_check(code), .Bus_conflict(conflict)
    );

    function automatic int exp_code(input logic [23:0] e);
        for (int i = 23; i >= 0; i--)
            if (e[i]) return i;
        return 31;
    endfunction

    function automatic int ones(input logic [23:0] e);
        int n = 0;
        for (int i = 0; i < 24; i++) n += int'(e[i]);
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_comb(input string tag);
        int c;
        logic [31:0] v;
        #1;
        c = exp_code(enc);
        v = (c < 24) ? src[c] : 32'h0;
        chk({tag, "_code"}, {27'h0, code}, 32'(c));
        chk({tag, "_bus"}, bus, v);
    endtask

    task automatic tick(input string tag);
        logic [23:0] e;
        e = enc;
        @(posedge clock);
        if (clear && ones(e) > 1) m_conf = 1'b1;
        #1;
        chk({tag, "_conflict"}, {31'h0, conflict}, {31'h0, m_conf});
    endtask

    task automatic pulse_clear(input string tag);
        #2 clear = 1'b0;
        #1;
        m_conf = 1'b0;
        chk({tag, "_clear"}, {31'h0, conflict}, 32'h0);
        #1 clear = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 24; i++) src[i] = 32'h5000_0000 + i;
        #2;
        chk("reset_conflict", {31'h0, conflict}, 32'h0);
        enc = 24'h000003;
        check_comb("comb_in_reset");
        @(posedge clock);
        #1;
        chk("held_in_reset", {31'h0, conflict}, 32'h0);
        enc = 24'h0;
        @(negedge clock) clear = 1'b1;
        check_comb("none");
        tick("none");
        for (int i = 0; i < 24; i++) src[i] = '0;
        src[0] = 32'hAAAA_AAAA; enc = 24'h000001; check_comb("r0");
        src[1] = 32'hBBBB_BBBB; enc = 24'h000002; check_comb("r1");
        src[23] = 32'hCCCC_CCCC; enc = 24'h800000; check_comb("csign");
        for (int i = 0; i < 24; i++) src[i] = 32'h1000_0000 + i;
        for (int i = 0; i < 24; i++) begin
            enc = 24'h1 << i;
            check_comb($sformatf("walk%0d", i));
        end
        tick("walk_end");
        src[0] = 32'd1; src[1] = 32'd2; enc = 24'h000003;
        check_comb("r1_wins");
        chk("r1_wins_val", bus, 32'd2);
        tick("conflict_set");
        chk("conflict_is_set", {31'h0, conflict}, 32'h1);
        enc = 24'h000001;
        for (int i = 0; i < 4; i++) tick("sticky");
        enc = 24'h0;
        tick("zero_not_conflict");
        pulse_clear("mid");
        tick("after_clear");
        for (int k = 0; k < 300; k++) begin
            int r;
            for (int i = 0; i < 24; i++) src[i] = $urandom;
            r = $urandom_range(0, 9);
            if (r == 0) enc = '0;
            else if (r <= 2) enc = 24'($urandom);
            else enc = 24'h1 << $urandom_range(0, 23);
            check_comb("rand");
            tick("rand");
            if ($urandom_range(0, 19) == 0) pulse_clear("rand");
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
